fetch_de_stage: RTL and testbench
=================================

Name: fetch_de_stage

Overview:
Instruction-fetch unit and IF/DE pipeline register for the MIPS core. It owns the PC and issues single-outstanding requests to instruction memory. It presents the fetched instruction to decode. It consumes the hazard unit's stall_en (freeze), branch redirect, interrupt entry and eret return.

Parameters:
DATA_WIDTH, 32, instruction width
ADDR_WIDTH, 32, PC / memory address width
RESET_PC, 32'h0000_0000, first fetch address after reset
INT_VECTOR, 32'h0000_0180, interrupt handler entry address
NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_stall_en  in  1  freeze from hazard unit
i_branch_taken  in  1  redirect request from decode
i_branch_addr  in  ADDR_WIDTH  branch/jump target
i_int_req  in  1  external interrupt request (level)
i_eret  in  1  eret redirect, one-cycle pulse
i_epc  in  ADDR_WIDTH  return address for eret
o_imem_req  out  1  memory request strobe, one cycle per request
o_imem_addr  out  ADDR_WIDTH  request address, valid with o_imem_req
i_imem_valid  in  1  response valid; at most one response per request
i_imem_data  in  DATA_WIDTH  response instruction
o_instr  out  DATA_WIDTH  instruction in decode
o_pc_de  out  ADDR_WIDTH  PC of o_instr
o_valid_de  out  1  o_instr is a real instruction (0 = bubble)
o_epc_save  out  ADDR_WIDTH  EPC to coprocessor, valid with o_int_ack
o_int_ack  out  1  one-cycle pulse: interrupt taken

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=ISSUE, kill=0, int_mask=0.
  - o_instr=NOP_INSTR, o_pc_de=0, o_valid_de=0.
  - o_imem_req=0, o_int_ack=0, o_epc_save=0.
- o_imem_req and o_imem_addr (=pc) are registered-state decodes. o_imem_req=1 exactly in ISSUE cycles.
- States:
  - ISSUE: request pc, go WAIT.
  - WAIT: idle until i_imem_valid. Then:
    - kill=1: discard data, clear kill, go ISSUE.
    - i_stall_en=1: store data in 1-entry hold buffer, go HOLD.
    - Otherwise: load decode reg (instr, pc, valid=1), pc<=pc+4, go ISSUE.
  - HOLD: when i_stall_en=0, load decode reg from buffer, pc<=pc+4, go ISSUE.
- Stall: decode reg and pc frozen. Issuing/receiving memory traffic is unaffected; stall never drops a response.
- Redirect: target and decode action depend on source.
  - i_eret: target=i_epc, clear int_mask.
  - i_branch_taken: target=i_branch_addr.
  - Interrupt taken: target=INT_VECTOR.
  - Priority: eret > branch > interrupt. The lower source is ignored that cycle; the interrupt stays pending as a level.
  - On any redirect: pc<=target, regardless of i_stall_en.
  - Decode reg: branch redirect keeps the decode reg (delay slot). Eret and interrupt load bubble (NOP_INSTR, valid=0).
  - In ISSUE: the request goes out with the old pc; set kill=1, go WAIT.
  - In WAIT: set kill=1 (a redirect coinciding with i_imem_valid discards that data).
  - In HOLD: drop buffer, go ISSUE.
- Interrupt taken iff i_int_req & !int_mask & !i_stall_en & !i_branch_taken & !i_eret. On taking it:
  - o_int_ack=1 for one cycle.
  - o_epc_save = o_pc_de if o_valid_de, else pc.
  - Set int_mask=1.
- Arithmetic: pc+4 wraps modulo 2^ADDR_WIDTH. Addresses are not checked for alignment.
- i_imem_valid outside WAIT is ignored.
- Reset mid-request: state returns to ISSUE; a late response arrives in ISSUE and is ignored.

Test Plan:
- Reset then stream with memory latency 1: requests at 0x0,0x4,0x8 every 2 cycles. o_pc_de steps 0x0,0x4,0x8 with o_valid_de=1.
- i_stall_en=1 for 5 cycles while response for 0x8 arrives: decode holds 0x4; after release, 0x8 appears next cycle. No extra memory request during HOLD.
- i_branch_taken with i_branch_addr=0x100 in WAIT, response arrives same cycle: data discarded. Next request is 0x100; decode keeps delay-slot instruction.
- i_int_req=1 with o_pc_de=0x20 valid, no stall: o_int_ack pulse, o_epc_save=0x20. Next request 0x180, decode bubble. Second assertion ignored until i_eret.
- i_eret with i_epc=0x20 simultaneous with i_branch_taken to 0x300: next request 0x20, int_mask cleared. Pending i_int_req taken the following eligible cycle.
- Assert i_rst_n=0 in WAIT, release; late i_imem_valid ignored. First request is RESET_PC; all outputs at reset values while reset is held.

Source files
------------

// File: rtl/fetch_de_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request strobe per fetch; at most one response per request.
interface fetch_de_stage_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/fetch_de_stage.sv
// Fetch unit and IF/DE pipeline register: owns the PC, issues single-outstanding
// imem requests, and handles stall, branch, interrupt and eret redirects.
module fetch_de_stage #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR = ADDR_WIDTH'(32'h0000_0180),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_stall_en,
  input  logic                   i_branch_taken,
  input  logic [ADDR_WIDTH-1:0]  i_branch_addr,
  input  logic                   i_int_req,
  input  logic                   i_eret,
  input  logic [ADDR_WIDTH-1:0]  i_epc,
  fetch_de_stage_if.master       imem,
  output logic [DATA_WIDTH-1:0]  o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc_de,
  output logic                   o_valid_de,
  output logic [ADDR_WIDTH-1:0]  o_epc_save,
  output logic                   o_int_ack
);

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  kill_q, kill_d;
  logic                  int_mask_q, int_mask_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_de_q, pc_de_d;
  logic                  valid_de_q, valid_de_d;
  logic [ADDR_WIDTH-1:0] epc_save_q, epc_save_d;
  logic                  int_ack_q, int_ack_d;

  logic                  int_take;
  logic                  redirect;
  logic                  bubble;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] pc_inc;

  // Redirect source selection: eret > branch > interrupt.
  always_comb begin
    int_take = i_int_req & ~int_mask_q & ~i_stall_en & ~i_branch_taken & ~i_eret;
    redirect = i_eret | i_branch_taken | int_take;
    bubble   = i_eret | int_take;
    pc_inc   = pc_q + ADDR_WIDTH'(PC_STEP);
    if (i_eret) begin
      target = i_epc;
    end else if (i_branch_taken) begin
      target = i_branch_addr;
    end else begin
      target = INT_VECTOR;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    int_mask_d = int_mask_q;
    hold_d     = hold_q;
    instr_d    = instr_q;
    pc_de_d    = pc_de_q;
    valid_de_d = valid_de_q;
    epc_save_d = epc_save_q;
    int_ack_d  = 1'b0;

    case (state_q)
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem.valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_ISSUE;
          end else if (i_stall_en) begin
            hold_d  = imem.data;
            state_d = ST_HOLD;
          end else begin
            instr_d    = imem.data;
            pc_de_d    = pc_q;
            valid_de_d = 1'b1;
            pc_d       = pc_inc;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_HOLD: begin
        if (!i_stall_en) begin
          instr_d    = hold_q;
          pc_de_d    = pc_q;
          valid_de_d = 1'b1;
          pc_d       = pc_inc;
          state_d    = ST_ISSUE;
        end
      end
      default: state_d = ST_ISSUE;
    endcase

    // A redirect overrides the normal flow; any in-flight data is discarded.
    if (redirect) begin
      pc_d       = target;
      hold_d     = hold_q;
      instr_d    = bubble ? NOP_INSTR : instr_q;
      pc_de_d    = pc_de_q;
      valid_de_d = bubble ? 1'b0 : valid_de_q;
      case (state_q)
        ST_ISSUE: begin
          kill_d  = 1'b1;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          kill_d  = ~imem.valid;
          state_d = imem.valid ? ST_ISSUE : ST_WAIT;
        end
        default: begin
          kill_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      endcase
    end

    if (i_eret) begin
      int_mask_d = 1'b0;
    end
    if (int_take) begin
      int_mask_d = 1'b1;
      int_ack_d  = 1'b1;
      epc_save_d = valid_de_q ? pc_de_q : pc_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_ISSUE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      int_mask_q <= 1'b0;
      hold_q     <= '0;
      instr_q    <= NOP_INSTR;
      pc_de_q    <= '0;
      valid_de_q <= 1'b0;
      epc_save_q <= '0;
      int_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      int_mask_q <= int_mask_d;
      hold_q     <= hold_d;
      instr_q    <= instr_d;
      pc_de_q    <= pc_de_d;
      valid_de_q <= valid_de_d;
      epc_save_q <= epc_save_d;
      int_ack_q  <= int_ack_d;
    end
  end

  // Request strobe is a decode of ISSUE, held low while reset is asserted.
  assign imem.req   = i_rst_n & (state_q == ST_ISSUE);
  assign imem.addr  = pc_q;
  assign o_instr    = instr_q;
  assign o_pc_de    = pc_de_q;
  assign o_valid_de = valid_de_q;
  assign o_epc_save = epc_save_q;
  assign o_int_ack  = int_ack_q;

endmodule

// File: tb/tb_fetch_de_stage.sv
// Directed bench for fetch_de_stage: streaming, stall, branch, interrupt, eret,
// mid-request reset and PC wrap, with hand-computed expectations.
module tb_fetch_de_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall_en;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        int_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] instr;
  logic [31:0] pc_de;
  logic        valid_de;
  logic [31:0] epc_save;
  logic        int_ack;

  int tests;
  int fails;

  fetch_de_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();

  fetch_de_stage dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_stall_en     (stall_en),
    .i_branch_taken (branch_taken),
    .i_branch_addr  (branch_addr),
    .i_int_req      (int_req),
    .i_eret         (eret),
    .i_epc          (epc),
    .imem           (imem),
    .o_instr        (instr),
    .o_pc_de        (pc_de),
    .o_valid_de     (valid_de),
    .o_epc_save     (epc_save),
    .o_int_ack      (int_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},      32'(imem.req), 32'd0);
    chk({tag, "_addr"},     imem.addr,     32'h0);
    chk({tag, "_instr"},    instr,         NOP);
    chk({tag, "_pc_de"},    pc_de,         32'h0);
    chk({tag, "_valid_de"}, 32'(valid_de), 32'd0);
    chk({tag, "_int_ack"},  32'(int_ack),  32'd0);
    chk({tag, "_epc_save"}, epc_save,      32'h0);
  endtask

  task automatic resp(input logic v, input logic [31:0] d);
    imem.valid = v;
    imem.data  = d;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0; stall_en = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    int_req = 1'b0; eret = 1'b0; epc = '0;
    resp(1'b0, '0);

    // Reset state
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(imem.req), 32'd1);
    chk("first_addr", imem.addr, 32'h0);

    // Streaming at latency 1
    tick(); chk("wait_no_req", 32'(imem.req), 32'd0); resp(1'b1, dat(32'h0));
    tick(); resp(1'b0, '0);
    chk("s0_pc_de", pc_de, 32'h0); chk("s0_valid", 32'(valid_de), 32'd1);
    chk("s0_instr", instr, dat(32'h0)); chk("s0_req", 32'(imem.req), 32'd1);
    chk("s0_addr", imem.addr, 32'h4);
    tick(); resp(1'b1, dat(32'h4));
    tick(); resp(1'b0, '0);
    chk("s1_pc_de", pc_de, 32'h4); chk("s1_addr", imem.addr, 32'h8);

    // Stall for 5 cycles while the 0x8 response lands
    tick(); stall_en = 1'b1; resp(1'b1, dat(32'h8));
    tick(); resp(1'b0, '0);
    chk("hold_req", 32'(imem.req), 32'd0); chk("hold_pc_de", pc_de, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req_n", 32'(imem.req), 32'd0); chk("hold_pc_de_n", pc_de, 32'h4);
    end
    tick(); stall_en = 1'b0; chk("hold_last_pc_de", pc_de, 32'h4);
    tick();
    chk("rel_pc_de", pc_de, 32'h8); chk("rel_instr", instr, dat(32'h8));
    chk("rel_req", 32'(imem.req), 32'd1); chk("rel_addr", imem.addr, 32'hC);

    // Branch in WAIT coinciding with the response: data discarded
    tick(); branch_taken = 1'b1; branch_addr = 32'h100; resp(1'b1, dat(32'hC));
    tick(); branch_taken = 1'b0; resp(1'b0, '0);
    chk("br_req", 32'(imem.req), 32'd1); chk("br_addr", imem.addr, 32'h100);
    chk("br_slot_pc", pc_de, 32'h8); chk("br_slot_instr", instr, dat(32'h8));
    chk("br_slot_valid", 32'(valid_de), 32'd1);
    tick(); resp(1'b1, dat(32'h100));
    tick(); resp(1'b0, '0);
    chk("tgt_pc_de", pc_de, 32'h100); chk("tgt_addr", imem.addr, 32'h104);

    // Branch in ISSUE: request goes with old pc, its response is killed
    branch_taken = 1'b1; branch_addr = 32'h20;
    tick(); branch_taken = 1'b0;
    chk("bri_wait", 32'(imem.req), 32'd0); resp(1'b1, dat(32'h104));
    tick(); resp(1'b0, '0);
    chk("bri_addr", imem.addr, 32'h20); chk("bri_slot_pc", pc_de, 32'h100);
    tick(); resp(1'b1, dat(32'h20));
    tick(); resp(1'b0, '0);
    chk("i20_pc_de", pc_de, 32'h20); chk("i20_valid", 32'(valid_de), 32'd1);
    chk("i20_addr", imem.addr, 32'h24);

    // Interrupt with a valid instruction in decode
    int_req = 1'b1;
    tick();
    chk("int_ack", 32'(int_ack), 32'd1); chk("int_epc", epc_save, 32'h20);
    chk("int_bubble_v", 32'(valid_de), 32'd0); chk("int_bubble_i", instr, NOP);
    chk("int_wait", 32'(imem.req), 32'd0);
    resp(1'b1, dat(32'h24));
    tick(); resp(1'b0, '0);
    chk("int_ack_pulse", 32'(int_ack), 32'd0); chk("vec_addr", imem.addr, 32'h180);
    chk("vec_req", 32'(imem.req), 32'd1);
    tick(); resp(1'b1, dat(32'h180));
    tick(); resp(1'b0, '0);
    chk("vec_pc_de", pc_de, 32'h180); chk("int_masked", 32'(int_ack), 32'd0);
    chk("vec_next", imem.addr, 32'h184);

    // Eret beats a simultaneous branch, then the pending interrupt is retaken
    tick(); eret = 1'b1; epc = 32'h20; branch_taken = 1'b1; branch_addr = 32'h300;
    resp(1'b1, dat(32'h184));
    tick(); eret = 1'b0; branch_taken = 1'b0; resp(1'b0, '0);
    chk("eret_addr", imem.addr, 32'h20); chk("eret_req", 32'(imem.req), 32'd1);
    chk("eret_bubble", 32'(valid_de), 32'd0); chk("eret_no_ack", 32'(int_ack), 32'd0);
    tick();
    chk("reint_ack", 32'(int_ack), 32'd1); chk("reint_epc", epc_save, 32'h20);
    chk("reint_wait", 32'(imem.req), 32'd0);
    int_req = 1'b0; resp(1'b1, dat(32'h20));
    tick(); resp(1'b0, '0);
    chk("reint_pulse", 32'(int_ack), 32'd0); chk("reint_addr", imem.addr, 32'h180);

    // Reset while in WAIT; the late response lands in ISSUE and is ignored
    tick(); rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    tick(); rst_n = 1'b1; resp(1'b1, dat(32'h180));
    #1;
    chk("post_rst_req", 32'(imem.req), 32'd1); chk("post_rst_addr", imem.addr, 32'h0);
    tick(); resp(1'b0, '0);
    chk("late_ignored_v", 32'(valid_de), 32'd0); chk("late_wait", 32'(imem.req), 32'd0);
    tick(); chk("late_still_wait", 32'(imem.req), 32'd0); resp(1'b1, dat(32'h0));
    tick(); resp(1'b0, '0);
    chk("pr_pc_de", pc_de, 32'h0); chk("pr_valid", 32'(valid_de), 32'd1);
    chk("pr_instr", instr, dat(32'h0)); chk("pr_addr", imem.addr, 32'h4);

    // PC wraps modulo 2^32
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick(); branch_taken = 1'b0; resp(1'b1, dat(32'h4));
    tick(); resp(1'b0, '0);
    chk("wrap_tgt", imem.addr, 32'hFFFF_FFFC); chk("wrap_slot", pc_de, 32'h0);
    tick(); resp(1'b1, dat(32'hFFFF_FFFC));
    tick(); resp(1'b0, '0);
    chk("wrap_pc_de", pc_de, 32'hFFFF_FFFC); chk("wrap_addr", imem.addr, 32'h0);
    chk("wrap_req", 32'(imem.req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
